// File: rtl/gemini_pipe_pkg.sv
// rtl/gemini_pipe_pkg.sv - shared types and helpers for the pipe_reg_skid stage
// Contents: pipe_state_e (EMPTY/FULL/SKID, value equals beats held),
//           LANES_MAX, lane_lsb() payload slice helper.
package gemini_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int LANES_MAX = 4;

  // Lowest bit of lane 'lane' inside a packed multi-lane payload.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// rtl/pipe_lane_reg.sv - one lane entry: valid bit plus W-bit payload
// Ports: clk, rst (sync, active-high), clr (zero entry), load (capture d_*),
//        d_valid/d_data (next entry), q_valid/q_data (held entry).
module pipe_lane_reg
  import gemini_pipe_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  // Bubble lanes are stored with zero data so invalid lanes always read zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_valid ? d_data : '0;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - multi-lane pipeline register with optional 2-entry skid buffer
// Ports: clk, rst (sync, active-high), flush (applies when out_ready=1),
//        exception_flush (unconditional), in_valid/in_data/in_ready (upstream),
//        out_valid/out_data/out_ready (downstream), occupancy (beats held).
module pipe_reg_skid
  import gemini_pipe_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int LANES  = 2,
  parameter int SKID   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    exception_flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  pipe_state_e state, state_n;

  logic [LANES-1:0]        s_valid;
  logic [LANES*DATA_W-1:0] s_data;

  logic beat_in, beat_out, in_xfer, out_xfer, kill;
  logic m_load_in, m_load_s, m_clr, s_load, s_clr;

  assign beat_in  = |in_valid;
  assign beat_out = |out_valid;
  assign in_xfer  = beat_in & in_ready;
  assign out_xfer = beat_out & out_ready;

  // A plain flush only lands on a cycle the held beat is consumed; otherwise
  // the requester keeps it asserted and normal hold behaviour continues.
  assign kill = exception_flush | (flush & out_ready);

  generate
    if (SKID != 0) begin : g_rdy_reg
      // Registered ready: depends only on state, no path from out_ready.
      assign in_ready = (state != ST_SKID);
    end else begin : g_rdy_comb
      assign in_ready = !beat_out || out_ready;
    end
  endgenerate

  assign occupancy = 2'(state);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    m_clr     = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    if (kill) begin
      state_n = ST_EMPTY;
      m_clr   = 1'b1;
      s_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_load_in = 1'b1;
            state_n   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_xfer && in_xfer) begin
            m_load_in = 1'b1;
          end else if (out_xfer) begin
            m_clr   = 1'b1;
            state_n = ST_EMPTY;
          end else if (in_xfer && (SKID != 0)) begin
            s_load  = 1'b1;
            state_n = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            m_load_s = 1'b1;
            s_clr    = 1'b1;
            state_n  = ST_FULL;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, DATA_W);

    logic              m_d_valid;
    logic [DATA_W-1:0] m_d_data;

    // M refills from S when draining the skid entry, otherwise from the input.
    assign m_d_valid = m_load_s ? s_valid[i]              : in_valid[i];
    assign m_d_data  = m_load_s ? s_data[LSB +: DATA_W]   : in_data[LSB +: DATA_W];

    pipe_lane_reg #(.W(DATA_W)) u_m (
      .clk     (clk),
      .rst     (rst),
      .clr     (m_clr),
      .load    (m_load_in | m_load_s),
      .d_valid (m_d_valid),
      .d_data  (m_d_data),
      .q_valid (out_valid[i]),
      .q_data  (out_data[LSB +: DATA_W])
    );

    if (SKID != 0) begin : g_s
      pipe_lane_reg #(.W(DATA_W)) u_s (
        .clk     (clk),
        .rst     (rst),
        .clr     (s_clr),
        .load    (s_load),
        .d_valid (in_valid[i]),
        .d_data  (in_data[LSB +: DATA_W]),
        .q_valid (s_valid[i]),
        .q_data  (s_data[LSB +: DATA_W])
      );
    end else begin : g_no_s
      assign s_valid[i]            = 1'b0;
      assign s_data[LSB +: DATA_W] = '0;
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb/tb_pipe_reg_skid.sv - self-checking bench for pipe_reg_skid (SKID=1 and SKID=0 builds)
module tb_pipe_reg_skid;

  localparam int DW = 16;
  localparam int LN = 2;

  typedef struct packed {
    logic [LN-1:0]    v;
    logic [LN*DW-1:0] d;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst, flush, exception_flush, out_ready;
  logic [LN-1:0]    in_valid;
  logic [LN*DW-1:0] in_data;

  logic             rdy1, rdy0;
  logic [LN-1:0]    ov1, ov0;
  logic [LN*DW-1:0] od1, od0;
  logic [1:0]       occ1, occ0;

  int checks = 0;
  int errors = 0;
  beat_t sb [2][$];

  always #5 clk = ~clk;

  pipe_reg_skid #(.DATA_W(DW), .LANES(LN), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .occupancy(occ1)
  );

  pipe_reg_skid #(.DATA_W(DW), .LANES(LN), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step for one DUT: compare held outputs with the expected head
  // (or zero when nothing is held), then apply this edge's flush/pop/push.
  task automatic mon(input int k, input logic rdy, input logic [LN-1:0] ov,
                     input logic [LN*DW-1:0] od, input logic [1:0] occ);
    beat_t e;
    if (rst) begin
      sb[k].delete();
      return;
    end
    e = (sb[k].size() != 0) ? sb[k][0] : '0;
    chk($sformatf("out_valid[dut%0d]", k), 64'(ov), 64'(e.v));
    chk($sformatf("out_data[dut%0d]", k), 64'(od), 64'(e.d));
    chk($sformatf("no_in_xfer_at_occ2[dut%0d]", k), 64'((occ == 2'd2) && (|in_valid) && rdy), 64'd0);
    if (exception_flush || (flush && out_ready)) begin
      sb[k].delete();
    end else begin
      if ((|ov) && out_ready && sb[k].size() != 0) void'(sb[k].pop_front());
      if ((|in_valid) && rdy) begin
        e.v = in_valid;
        e.d = {in_valid[1] ? in_data[31:16] : 16'h0, in_valid[0] ? in_data[15:0] : 16'h0};
        sb[k].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, rdy1, ov1, od1, occ1);
    mon(0, rdy0, ov0, od0, occ0);
    if (!rst) chk("s_valid_without_m", 64'((|dut.s_valid) && !(|dut.out_valid)), 64'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exception_flush = 1'b0; out_ready = 1'b1;
    set_in(2'b00, 16'h0, 16'h0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(ov1), 64'd0);
    chk("reset_out_data", 64'(od1), 64'd0);
    chk("reset_occupancy", 64'(occ1), 64'd0);
    chk("reset_in_ready", 64'(rdy1), 64'd1);
    chk("reset_in_ready_skid0", 64'(rdy0), 64'd1);

    // Streaming: one beat per cycle, each visible the cycle after transfer.
    for (int k = 0; k < 4; k++) begin
      set_in(2'b11, 16'h11 + 16'(k), 16'h21 + 16'(k));
      step();
      chk("stream_occupancy", 64'(occ1), 64'd1);
      chk("stream_in_ready", 64'(rdy1), 64'd1);
      chk("stream_out_valid", 64'(ov1), 64'd3);
      chk("stream_lane0", 64'(od1[15:0]), 64'(16'h11 + 16'(k)));
    end
    set_in(2'b00, 16'h0, 16'h0);
    step();
    chk("stream_drained", 64'(occ1), 64'd0);

    // Skid fill: A held, B captured into S, C waits for ready.
    set_in(2'b11, 16'h31, 16'h51);
    step();
    set_in(2'b11, 16'h32, 16'h52); out_ready = 1'b0;
    #1;
    chk("fill_ready_full", 64'(rdy1), 64'd1);
    chk("skid0_ready_stalled", 64'(rdy0), 64'd0);
    step();
    chk("fill_occ2", 64'(occ1), 64'd2);
    set_in(2'b11, 16'h33, 16'h53);
    #1;
    chk("fill_ready_skid", 64'(rdy1), 64'd0);
    step();
    chk("fill_hold_occ2", 64'(occ1), 64'd2);
    chk("fill_hold_a", 64'(od1[15:0]), 64'h31);
    out_ready = 1'b1;
    #1;
    chk("release_ready_still0", 64'(rdy1), 64'd0);
    chk("skid0_ready_comb", 64'(rdy0), 64'd1);
    step();
    chk("release_b", 64'(od1[15:0]), 64'h32);
    chk("release_ready_back", 64'(rdy1), 64'd1);
    step();
    chk("release_c", 64'(od1[15:0]), 64'h33);
    set_in(2'b00, 16'h0, 16'h0);
    step();
    chk("release_empty", 64'(occ1), 64'd0);

    // Partial lanes: lane1 bubble must store zero data.
    set_in(2'b01, 16'h0042, 16'hDEAD);
    step();
    set_in(2'b00, 16'h0, 16'h0);
    chk("partial_valid", 64'(ov1), 64'd1);
    chk("partial_lane1_zero", 64'(od1[31:16]), 64'd0);
    step();

    // flush while stalled is ignored; takes effect once out_ready=1.
    set_in(2'b11, 16'h41, 16'h61);
    step();
    set_in(2'b11, 16'h42, 16'h62); out_ready = 1'b0;
    step();
    set_in(2'b11, 16'h43, 16'h63); flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_stall_occ", 64'(occ1), 64'd2);
      chk("flush_stall_data", 64'(od1), 64'h0061_0041);
    end
    out_ready = 1'b1;
    step();
    chk("flush_occ", 64'(occ1), 64'd0);
    chk("flush_out_valid", 64'(ov1), 64'd0);
    flush = 1'b0; set_in(2'b00, 16'h0, 16'h0);
    step();
    chk("flush_no_residue", 64'(ov1), 64'd0);

    // exception_flush during stall.
    set_in(2'b11, 16'h71, 16'h81);
    step();
    set_in(2'b11, 16'h72, 16'h82); out_ready = 1'b0;
    step();
    set_in(2'b00, 16'h0, 16'h0); exception_flush = 1'b1;
    step();
    exception_flush = 1'b0;
    chk("exc_occ", 64'(occ1), 64'd0);
    chk("exc_out_valid", 64'(ov1), 64'd0);
    chk("exc_out_data", 64'(od1), 64'd0);

    // rst together with exception_flush mid-SKID.
    out_ready = 1'b1;
    set_in(2'b11, 16'h91, 16'hA1);
    step();
    set_in(2'b11, 16'h92, 16'hA2); out_ready = 1'b0;
    step();
    chk("pre_rst_occ2", 64'(occ1), 64'd2);
    set_in(2'b00, 16'h0, 16'h0); rst = 1'b1; exception_flush = 1'b1;
    step();
    rst = 1'b0; exception_flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(rdy1), 64'd1);
    chk("rst_occ", 64'(occ1), 64'd0);
    chk("rst_out_data", 64'(od1), 64'd0);

    // SKID=0 back-to-back transfers with out_ready=1.
    set_in(2'b11, 16'hB1, 16'hC1);
    step();
    set_in(2'b11, 16'hB2, 16'hC2);
    #1;
    chk("skid0_b2b_ready", 64'(rdy0), 64'd1);
    step();
    chk("skid0_b2b_data", 64'(od0), 64'h00C2_00B2);
    set_in(2'b00, 16'h0, 16'h0);
    step(); step();

    chk("sb_empty_dut", 64'(sb[1].size()), 64'd0);
    chk("sb_empty_dut0", 64'(sb[0].size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised successor of the fixed-field ID2→EXC pipeline register.
- Carries LANES independent lanes, each an opaque DATA_W-bit payload with its own valid bit. Decode/execute bundles are packed into the payload by the instantiating stage.
- Replaces the implicit stall input with a valid/ready handshake. Keeps the flush / exception_flush semantics.
- An optional 2-entry skid buffer registers in_ready, which breaks the combinational ready path between stages.

Parameters:
- DATA_W, 256: payload width per lane, in bits.
- LANES, 2: issue lanes per beat. Legal range 1..4.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready. 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush (branch redirect); takes effect only on a cycle where out_ready=1.
- exception_flush  in  1  unconditional flush; takes effect on any cycle.
- in_valid  in  LANES  per-lane valid of the incoming beat.
- in_data  in  LANES*DATA_W  incoming payload; lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  1  stage can accept a beat this cycle.
- out_valid  out  LANES  per-lane valid of the held beat.
- out_data  out  LANES*DATA_W  held payload.
- out_ready  in  1  downstream accepts the beat (equivalent to !stall).
- occupancy  out  2  beats held: 0, 1 or 2.

Behaviour:
- Beat presence: a beat is present when |in_valid. In a beat, lanes with in_valid[i]=0 are bubbles; they are stored with valid=0 and data=0.
- Input transfer: occurs on a clock edge when |in_valid & in_ready.
- Output transfer: occurs on a clock edge when |out_valid & out_ready.
- Storage: main register M (drives the outputs) plus skid register S (present only when SKID=1).
- State machine (SKID=1):
  - EMPTY (M and S invalid):
    - input transfer → FULL; M is loaded.
  - FULL (M valid, S invalid):
    - output transfer with no input → EMPTY.
    - output transfer with input → FULL; M is reloaded with the new beat.
    - input with no output transfer → SKID; the new beat is captured into S.
  - SKID (M and S valid):
    - output transfer → FULL; M←S, then S is cleared.
    - in_ready=0 in this state.
- SKID=1 ready rule: in_ready = (state != SKID), a pure function of registered state.
- SKID=0: states EMPTY and FULL only; in_ready = !(|out_valid) | out_ready.
- Precedence at each edge, highest first:
  1. rst: M and S cleared to zero; state EMPTY.
  2. exception_flush: M and S cleared; state EMPTY. The incoming beat is dropped and the held beat is not delivered, so downstream must also honour exception_flush.
  3. flush & out_ready: the held M beat counts as delivered. S and the incoming beat are discarded; state EMPTY.
  4. flush & !out_ready: flush is ignored and normal hold behaviour applies. The requester keeps flush asserted until it takes effect.
  5. Otherwise normal handshake operation.
- Clearing: zeroes both valid and data bits, for deterministic waveforms and lockstep comparison.
- Reset values: out_valid=0, out_data=0, occupancy=0. in_ready=1 in the first cycle after rst deasserts; during rst, in_ready follows the rule for state EMPTY.
- Held data: M and S data do not change while held; there is no unintended overwrite.
- Latency: an input beat appears on the outputs the edge after the transfer. Throughput is one beat per cycle with no bubbles while out_ready=1.
- Occupancy encoding: EMPTY=0, FULL=1, SKID=2.
- Reset mid-operation: reset discards all held beats; no partial output.
- Assertions for verification:
  - S is never valid while M is invalid.
  - When SKID=1, no input transfer occurs while occupancy=2.
  - out_data lanes whose valid bit is 0 read as zero.

Decomposition:
- Shared package (gemini_pipe_pkg):
  - state encoding: EMPTY, FULL, SKID.
  - LANES_MAX=4 constant.
  - lane slice helper function.
- Sub-module pipe_lane_reg: one DATA_W+1 entry register with load/clear enables, instantiated for M and S per lane.
- Top level: owns the FSM, the precedence logic and the ready logic.

Test Plan:
- Streaming: after reset, LANES=2, out_ready=1, 4 beats in consecutive cycles (lane0 data 0x11..0x14) → each appears one cycle later, occupancy=1 throughout, in_ready=1, zero bubbles.
- Skid fill: beat A accepted, then out_ready=0 while beats B and C are offered → occupancy=1 then 2; in_ready=0 after B is captured. Releasing out_ready then delivers A, B, C in order, with C accepted the cycle in_ready returns to 1.
- Partial lanes: in_valid=2'b01, lane1 data=0xDEAD → out_valid=2'b01, lane1 out_data=0.
- flush during stall: occupancy=2, flush=1, out_ready=0 for 3 cycles → state held, out_data unchanged. Then out_ready=1 with flush=1 → next cycle occupancy=0, out_valid=0; S beat and incoming beat never appear.
- exception_flush during stall: occupancy=2, out_ready=0, exception_flush=1 → next cycle occupancy=0, outputs zero.
- rst priority: rst=1 and exception_flush=1 both asserted mid-SKID → all outputs zero and in_ready=1 the cycle after rst falls.
- SKID=0 build: out_ready=0 with M full → in_ready=0 in the same cycle. out_ready=1 → in_ready=1 combinationally, with back-to-back transfer.
